// File: rtl/mb_tx.sv
// Mainband transmit path: buffers 64-byte flits and serializes each over
// 16 data lanes as 4 fragments x 8 UIs, with a 1111_0000 valid pattern.
module mb_tx #(
  parameter int FLIT_BUF_DEPTH = 4
) (
  input  logic            periph_clkPins_i,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [63:0][7:0] data_i,
  output logic            ready_o,
  output logic [15:0]     dataPins_o,
  output logic            valid_oPin,
  output logic            busy_o,
  output logic            flit_sent_o
);

  localparam int PW = $clog2(FLIT_BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FLIT_BUF_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [63:0][7:0] flit_buf_r [FLIT_BUF_DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    rd_next_s;
  logic [CW-1:0]    count_r;
  state_t           state_r;
  logic [2:0]       ui_r;
  logic [1:0]       frag_r;
  logic [2:0]       ui_next_s;
  logic [1:0]       frag_next_s;
  logic             push_s;
  logic             pop_s;
  logic             more_s;
  logic [63:0][7:0] cur_flit_s;
  logic [63:0][7:0] next_flit_s;

  // Lane b carries bit ui of byte frag*16+b.
  function automatic logic [15:0] lanes(input logic [63:0][7:0] flit,
                                        input logic [1:0] frag,
                                        input logic [2:0] ui);
    logic [15:0] r;
    r = 16'h0000;
    for (int b = 0; b < 16; b++) begin
      r[b] = flit[{frag, 4'(b)}][ui];
    end
    return r;
  endfunction

  assign ready_o     = (count_r < DEPTH_C);
  assign push_s      = valid_i && ready_o;
  assign pop_s       = (state_r == SEND) && (frag_r == 2'd3) && (ui_r == 3'd7);
  assign rd_next_s   = rd_ptr_r + PW'(1);
  // A flit pushed on the completing edge is not yet in the buffer, so forward it.
  assign more_s      = (count_r > CW'(1)) || push_s;
  assign cur_flit_s  = flit_buf_r[rd_ptr_r];
  assign next_flit_s = (count_r > CW'(1)) ? flit_buf_r[rd_next_s] : data_i;

  // Next UI/fragment position within the current flit.
  always_comb begin
    ui_next_s = ui_r + 3'd1;
    if (ui_r == 3'd7) begin
      frag_next_s = frag_r + 2'd1;
    end else begin
      frag_next_s = frag_r;
    end
  end

  // Flit storage write port; contents survive reset.
  always_ff @(posedge periph_clkPins_i) begin
    if (push_s && !reset) begin
      flit_buf_r[wr_ptr_r] <= data_i;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge periph_clkPins_i) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Serializer FSM; ui_r/frag_r name the UI currently on the pins.
  always_ff @(posedge periph_clkPins_i) begin
    if (reset) begin
      state_r     <= IDLE;
      ui_r        <= 3'd0;
      frag_r      <= 2'd0;
      dataPins_o  <= 16'h0000;
      valid_oPin  <= 1'b0;
      busy_o      <= 1'b0;
      flit_sent_o <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ui_r        <= 3'd0;
          frag_r      <= 2'd0;
          flit_sent_o <= 1'b0;
          if (count_r != CW'(0)) begin
            state_r    <= SEND;
            dataPins_o <= lanes(cur_flit_s, 2'd0, 3'd0);
            valid_oPin <= 1'b1;
            busy_o     <= 1'b1;
          end else begin
            dataPins_o <= 16'h0000;
            valid_oPin <= 1'b0;
            busy_o     <= 1'b0;
          end
        end
        SEND: begin
          if (pop_s) begin
            ui_r        <= 3'd0;
            frag_r      <= 2'd0;
            flit_sent_o <= 1'b0;
            if (more_s) begin
              dataPins_o <= lanes(next_flit_s, 2'd0, 3'd0);
              valid_oPin <= 1'b1;
              busy_o     <= 1'b1;
            end else begin
              state_r    <= IDLE;
              dataPins_o <= 16'h0000;
              valid_oPin <= 1'b0;
              busy_o     <= 1'b0;
            end
          end else begin
            ui_r        <= ui_next_s;
            frag_r      <= frag_next_s;
            dataPins_o  <= lanes(cur_flit_s, frag_next_s, ui_next_s);
            valid_oPin  <= (ui_next_s < 3'd4);
            busy_o      <= 1'b1;
            flit_sent_o <= (frag_next_s == 2'd3) && (ui_next_s == 3'd7);
          end
        end
        default: begin
          state_r     <= IDLE;
          ui_r        <= 3'd0;
          frag_r      <= 2'd0;
          dataPins_o  <= 16'h0000;
          valid_oPin  <= 1'b0;
          busy_o      <= 1'b0;
          flit_sent_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb_tx.sv
// Directed and randomized bench for mb_tx; a behavioural receiver rebuilds
// each flit from the captured pin stream and compares it to the sent bytes.
module tb_mb_tx;

  typedef logic [63:0][7:0] flit_t;

  logic        clk;
  logic        reset;
  logic        valid_i;
  flit_t       data_i;
  logic        ready_o;
  logic [15:0] dataPins_o;
  logic        valid_oPin;
  logic        busy_o;
  logic        flit_sent_o;

  int checks;
  int failures;
  int edge_cnt;
  logic feed_en;
  logic rand_gap;

  flit_t       tx_q[$];
  flit_t       acc_q[$];
  int          acc_edge[$];
  int          cap_edge[$];
  logic [15:0] cap_pins[$];
  logic        cap_val[$];
  logic        cap_sent[$];
  logic        cap_busy[$];
  logic        cap_ready[$];

  mb_tx #(.FLIT_BUF_DEPTH(4)) dut (
    .periph_clkPins_i(clk),
    .reset(reset),
    .valid_i(valid_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .dataPins_o(dataPins_o),
    .valid_oPin(valid_oPin),
    .busy_o(busy_o),
    .flit_sent_o(flit_sent_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (rand_gap) feed_en = ($urandom_range(0, 3) != 0);
    valid_i = feed_en && (tx_q.size() != 0);
    if (valid_i) data_i = tx_q[0];
    else data_i = '0;
  endtask

  // One clock: sample at negedge, apply handshake, update inputs after the edge.
  task automatic cycle();
    logic acc;
    @(negedge clk);
    cap_edge.push_back(edge_cnt);
    cap_pins.push_back(dataPins_o);
    cap_val.push_back(valid_oPin);
    cap_sent.push_back(flit_sent_o);
    cap_busy.push_back(busy_o);
    cap_ready.push_back(ready_o);
    acc = (valid_i === 1'b1) && (ready_o === 1'b1) && !reset;
    @(posedge clk);
    #1;
    edge_cnt++;
    if (acc) begin
      acc_q.push_back(tx_q.pop_front());
      acc_edge.push_back(edge_cnt);
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_cap();
    cap_edge.delete(); cap_pins.delete(); cap_val.delete();
    cap_sent.delete(); cap_busy.delete(); cap_ready.delete();
    acc_q.delete(); acc_edge.delete();
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && acc_q.size() < n; i++) cycle();
    chk({tag, "_accepted"}, acc_q.size(), n);
  endtask

  function automatic flit_t rand_flit();
    flit_t f;
    for (int k = 0; k < 64; k++) f[k] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  // Receiver model: every 32 busy UIs form one flit; UI h*8+j, lane b -> bit j of byte h*16+b.
  task automatic analyze(input string tag);
    flit_t       rx;
    logic [31:0] vpat;
    logic [31:0] spat;
    int nb, t, k, first_e, idle_bad;
    nb = 0; idle_bad = 0; first_e = 0;
    rx = '0; vpat = 32'h0; spat = 32'h0;
    for (int i = 0; i < cap_edge.size(); i++) begin
      if (cap_busy[i] === 1'b1) begin
        t = nb % 32;
        if (t == 0) begin
          rx = '0; vpat = 32'h0; spat = 32'h0; first_e = cap_edge[i];
        end
        for (int b = 0; b < 16; b++) rx[(t / 8) * 16 + b][t % 8] = cap_pins[i][b];
        vpat[t] = cap_val[i];
        spat[t] = cap_sent[i];
        if (t == 31) begin
          k = nb / 32;
          if (k < acc_q.size()) chk($sformatf("%s_bytes%0d", tag, k), rx, acc_q[k]);
          else chk($sformatf("%s_extra_flit%0d", tag, k), k, acc_q.size());
          chk($sformatf("%s_valid%0d", tag, k), vpat, 32'h0F0F0F0F);
          chk($sformatf("%s_sent%0d", tag, k), spat, 32'h80000000);
          chk($sformatf("%s_span%0d", tag, k), cap_edge[i] - first_e, 31);
        end
        nb++;
      end else if (cap_pins[i] !== 16'h0000 || cap_val[i] !== 1'b0 || cap_sent[i] !== 1'b0) begin
        idle_bad++;
      end
    end
    chk({tag, "_busy_uis"}, nb, 32 * acc_q.size());
    chk({tag, "_idle_quiet"}, idle_bad, 0);
  endtask

  initial begin
    flit_t f;
    int first_busy, last_busy, nbusy, nsent, bad, t, rst_e, first_sent;
    int sent_e[$];
    checks = 0; failures = 0; edge_cnt = 0;
    feed_en = 1'b1; rand_gap = 1'b0;
    reset = 1'b1; valid_i = 1'b1; data_i = '1;

    // Reset state, with valid_i held high to show it is ignored.
    run(3);
    chk("rst_ready", cap_ready[$], 1);
    chk("rst_busy", cap_busy[$], 0);
    chk("rst_pins", cap_pins[$], 0);
    chk("rst_valid", cap_val[$], 0);
    chk("rst_sent", cap_sent[$], 0);
    reset = 1'b0; drive();
    run(2);
    chk("rst_no_accept", cap_busy[$], 0);
    clear_cap();

    // Single flit, byte k = k.
    for (int k = 0; k < 64; k++) f[k] = 8'(k);
    tx_q.push_back(f); drive();
    wait_acc("s1", 1, 10);
    run(40);
    first_busy = -1; nsent = 0; first_sent = -1;
    for (int i = 0; i < cap_edge.size(); i++) begin
      if (cap_busy[i] === 1'b1 && first_busy < 0) begin
        first_busy = cap_edge[i];
        chk("s1_ui0_pins", cap_pins[i], 16'hAAAA);
      end
      if (cap_sent[i] === 1'b1) begin
        nsent++;
        if (first_sent < 0) first_sent = cap_edge[i];
      end
    end
    chk("s1_latency", first_busy, acc_edge[0] + 1);
    chk("s1_sent_edge", first_sent, acc_edge[0] + 32);
    chk("s1_sent_count", nsent, 1);
    analyze("s1");
    clear_cap();

    // All bytes 0x80: only UI7 of each fragment carries ones.
    for (int k = 0; k < 64; k++) f[k] = 8'h80;
    tx_q.push_back(f); drive();
    wait_acc("s2", 1, 10);
    run(40);
    nbusy = 0; bad = 0;
    for (int i = 0; i < cap_edge.size(); i++) begin
      if (cap_busy[i] === 1'b1) begin
        t = nbusy % 8;
        if (cap_pins[i] !== ((t == 7) ? 16'hFFFF : 16'h0000)) bad++;
        nbusy++;
      end
    end
    chk("s2_pin_pattern", bad, 0);
    analyze("s2");
    clear_cap();

    // Four flits back-to-back.
    for (int n = 0; n < 4; n++) tx_q.push_back(rand_flit());
    drive();
    wait_acc("s3", 4, 10);
    chk("s3_b2b_accept", acc_edge[3] - acc_edge[0], 3);
    run(150);
    nbusy = 0; first_busy = -1; last_busy = -1; sent_e.delete();
    for (int i = 0; i < cap_edge.size(); i++) begin
      if (cap_busy[i] === 1'b1) begin
        nbusy++;
        if (first_busy < 0) first_busy = cap_edge[i];
        last_busy = cap_edge[i];
      end
      if (cap_sent[i] === 1'b1) sent_e.push_back(cap_edge[i]);
    end
    chk("s3_busy_count", nbusy, 128);
    chk("s3_busy_span", last_busy - first_busy, 127);
    chk("s3_sent_pulses", sent_e.size(), 4);
    if (sent_e.size() == 4) begin
      for (int p = 1; p < 4; p++) chk($sformatf("s3_sent_gap%0d", p), sent_e[p] - sent_e[p-1], 32);
    end
    chk("s3_busy_after", cap_busy[$], 0);
    analyze("s3");
    clear_cap();

    // Six flits offered continuously into a depth-4 buffer.
    for (int n = 0; n < 6; n++) tx_q.push_back(rand_flit());
    drive();
    wait_acc("s4", 6, 120);
    run(220);
    first_sent = -1; bad = -1;
    for (int i = 0; i < cap_edge.size(); i++) begin
      if (cap_sent[i] === 1'b1 && first_sent < 0) first_sent = cap_edge[i];
      if (cap_ready[i] === 1'b0 && bad < 0) bad = cap_edge[i];
    end
    nbusy = 0;
    for (int a = 0; a < acc_edge.size(); a++) if (acc_edge[a] <= bad) nbusy++;
    chk("s4_full_at_4", nbusy, 4);
    for (int i = 0; i < cap_edge.size(); i++) begin
      if (cap_edge[i] == first_sent) chk("s4_ready_low_before_pop", cap_ready[i], 0);
      if (cap_edge[i] == first_sent + 1) chk("s4_ready_after_pop", cap_ready[i], 1);
    end
    if (acc_edge.size() > 4) chk("s4_fifth_accept", acc_edge[4], first_sent + 2);
    analyze("s4");
    clear_cap();

    // Reset at UI 13 of a flit with two more buffered.
    for (int n = 0; n < 3; n++) tx_q.push_back(rand_flit());
    drive();
    wait_acc("s5", 3, 10);
    for (int i = 0; i < 40 && edge_cnt < acc_edge[0] + 14; i++) cycle();
    reset = 1'b1;
    cycle();
    chk("s5_busy_before_reset", cap_busy[$], 1);
    rst_e = edge_cnt;
    reset = 1'b0;
    cycle();
    chk("s5_pins_after", cap_pins[$], 0);
    chk("s5_valid_after", cap_val[$], 0);
    chk("s5_busy_after", cap_busy[$], 0);
    chk("s5_ready_after", cap_ready[$], 1);
    run(60);
    nbusy = 0; nsent = 0;
    for (int i = 0; i < cap_edge.size(); i++) begin
      if (cap_edge[i] >= rst_e && cap_busy[i] !== 1'b0) nbusy++;
      if (cap_sent[i] !== 1'b0) nsent++;
    end
    chk("s5_flushed", nbusy, 0);
    chk("s5_no_sent", nsent, 0);
    clear_cap();
    tx_q.push_back(rand_flit()); drive();
    wait_acc("s5b", 1, 10);
    run(40);
    first_busy = -1;
    for (int i = 0; i < cap_edge.size(); i++)
      if (cap_busy[i] === 1'b1 && first_busy < 0) first_busy = cap_edge[i];
    chk("s5b_latency", first_busy, acc_edge[0] + 1);
    analyze("s5b");
    clear_cap();

    // Loopback of 100 random flits with random upstream gaps.
    for (int n = 0; n < 100; n++) tx_q.push_back(rand_flit());
    rand_gap = 1'b1; drive();
    wait_acc("s6", 100, 6000);
    rand_gap = 1'b0; feed_en = 1'b1; drive();
    run(200);
    analyze("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
